// File: rtl/clause_status_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : clause_status_scanner_if
// Purpose  : Batch handshake and data bus between the clause status scanner,
//            the comparator that validates each batch, and the OR stage that
//            merges newly false literals into the stored batch.
// Revision : 1.0  initial release
// ============================================================================
interface clause_status_scanner_if #(
  parameter int W   = 48,
  parameter int BID = 2
);
  logic           mem_mask_valid;
  logic           mem_mask_ready;
  logic [BID-1:0] batch_idx;
  logic [W-1:0]   assign_out;
  logic [W-1:0]   or_result_in;

  // Comparator / OR-stage side
  modport master (
    output mem_mask_valid,
    output or_result_in,
    input  mem_mask_ready,
    input  batch_idx,
    input  assign_out
  );

  // Scanner side
  modport slave (
    input  mem_mask_valid,
    input  or_result_in,
    output mem_mask_ready,
    output batch_idx,
    output assign_out
  );
endinterface
`default_nettype wire

// File: rtl/clause_status_scanner.sv
`default_nettype none
// ============================================================================
// Module   : clause_status_scanner
// Purpose  : Holds the per-literal falsity store for every clause, walks it
//            one batch per accepted beat, writes back the OR-merged batch and
//            reports the lowest conflicting clause and lowest unit clause.
// Revision : 1.0  initial release
// ============================================================================
module clause_status_scanner #(
  parameter int NUM_CLAUSES           = 64,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter int NUM_VARS_PER_CLAUSE   = 3,
  localparam int W   = NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE,
  localparam int NB  = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
  localparam int CID = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
  localparam int BID = (NB > 1) ? $clog2(NB) : 1,
  localparam int LID = (NUM_VARS_PER_CLAUSE > 1) ? $clog2(NUM_VARS_PER_CLAUSE) : 1
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    start,
  input  wire logic                    clear,
  clause_status_scanner_if.slave       bus,
  output logic                         busy,
  output logic                         done,
  output logic                         conflict,
  output logic [CID-1:0]               conflict_clause,
  output logic                         unit_found,
  output logic [CID-1:0]               unit_clause,
  output logic [LID-1:0]               unit_lit_pos
);

  localparam int CPC = NUM_CLAUSES_PER_CYCLE;
  localparam int NV  = NUM_VARS_PER_CLAUSE;
  localparam int CW  = (CPC > 1) ? $clog2(CPC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BID-1:0]  batch_idx_q;
  logic [W-1:0]    store_q [NB];
  logic            conflict_q;
  logic [CID-1:0]  conflict_clause_q;
  logic            unit_found_q;
  logic [CID-1:0]  unit_clause_q;
  logic [LID-1:0]  unit_lit_pos_q;

  logic            w_beat;
  logic            w_last;
  logic            w_batch_conf;
  logic [CW-1:0]   w_conf_idx;
  logic            w_batch_unit;
  logic [CW-1:0]   w_unit_idx;
  logic [LID-1:0]  w_unit_pos;

  // Global clause id from batch number and slot within the batch
  function automatic logic [CID-1:0] f_gid(input logic [BID-1:0] b,
                                           input logic [CW-1:0]  c);
    int g;
    g = int'(b) * CPC + int'(c);
    return g[CID-1:0];
  endfunction

  assign w_beat = (state_q == ST_SCAN) && bus.mem_mask_valid;
  assign w_last = (batch_idx_q == BID'(NB - 1));

  assign bus.mem_mask_ready = (state_q == ST_SCAN);
  assign bus.batch_idx      = batch_idx_q;
  assign bus.assign_out     = store_q[batch_idx_q];

  assign busy            = (state_q == ST_SCAN);
  assign done            = (state_q == ST_DONE);
  assign conflict        = conflict_q;
  assign conflict_clause = conflict_clause_q;
  assign unit_found      = unit_found_q;
  assign unit_clause     = unit_clause_q;
  assign unit_lit_pos    = unit_lit_pos_q;

  // Classify every clause of the merged batch; walking high-to-low leaves the lowest hit
  always_comb begin
    int            cnt;
    logic [LID-1:0] pos;
    w_batch_conf = 1'b0;
    w_conf_idx   = '0;
    w_batch_unit = 1'b0;
    w_unit_idx   = '0;
    w_unit_pos   = '0;
    cnt          = 0;
    pos          = '0;
    for (int c = CPC - 1; c >= 0; c--) begin
      cnt = 0;
      pos = '0;
      for (int l = 0; l < NV; l++) begin
        if (bus.or_result_in[c*NV + l]) cnt = cnt + 1;
        else                            pos = LID'(l);
      end
      if (cnt == NV) begin
        w_batch_conf = 1'b1;
        w_conf_idx   = CW'(c);
      end
      if (cnt == NV - 1) begin
        w_batch_unit = 1'b1;
        w_unit_idx   = CW'(c);
        w_unit_pos   = pos;
      end
    end
  end

  // Next-state logic: a conflict in the current beat ends the pass early
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: if (w_beat && (w_batch_conf || w_last)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Store, batch pointer and first-found result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) store_q[b] <= '0;
      batch_idx_q       <= '0;
      conflict_q        <= 1'b0;
      conflict_clause_q <= '0;
      unit_found_q      <= 1'b0;
      unit_clause_q     <= '0;
      unit_lit_pos_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (clear) begin
            for (int b = 0; b < NB; b++) store_q[b] <= '0;
          end
          if (clear || start) begin
            batch_idx_q       <= '0;
            conflict_q        <= 1'b0;
            conflict_clause_q <= '0;
            unit_found_q      <= 1'b0;
            unit_clause_q     <= '0;
            unit_lit_pos_q    <= '0;
          end
        end
        ST_SCAN: begin
          if (w_beat) begin
            store_q[batch_idx_q] <= bus.or_result_in;
            if (!conflict_q && w_batch_conf) begin
              conflict_q        <= 1'b1;
              conflict_clause_q <= f_gid(batch_idx_q, w_conf_idx);
            end
            if (!unit_found_q && w_batch_unit) begin
              unit_found_q   <= 1'b1;
              unit_clause_q  <= f_gid(batch_idx_q, w_unit_idx);
              unit_lit_pos_q <= w_unit_pos;
            end
            if (!(w_batch_conf || w_last)) batch_idx_q <= batch_idx_q + BID'(1);
          end
        end
        ST_DONE: batch_idx_q <= '0;
        default: batch_idx_q <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire
